// File: rtl/jtag_types_pkg.sv
// Shared FIFO configuration record and default build constants.
// Optional error flags are enabled with the JTAG_FIFO_ERR_EN macro.
package jtag_types_pkg;

  localparam int FIFO_WIDTH_DEF     = 8;
  localparam int FIFO_DEPTH_DEF     = 64;
  localparam int FIFO_AF_MARGIN_DEF = 4;
  localparam int FIFO_AE_LEVEL_DEF  = 4;
  localparam int FIFO_FWFT_DEF      = 1;

  typedef struct packed {
    int unsigned width;
    int unsigned depth;
    int unsigned af_level;
    int unsigned ae_level;
  } fifo_cfg_t;

  localparam fifo_cfg_t FIFO_CFG_DEF = '{
    width:    FIFO_WIDTH_DEF,
    depth:    FIFO_DEPTH_DEF,
    af_level: FIFO_DEPTH_DEF - FIFO_AF_MARGIN_DEF,
    ae_level: FIFO_AE_LEVEL_DEF
  };

  // Occupancy counter width: one extra bit so that DEPTH itself is representable.
  function automatic int fifo_cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/jtag_fifo_ram.sv
// Purpose: FIFO storage array, one synchronous write port and one asynchronous read port.
// Latency: write lands on the TCK edge; read data follows raddr combinationally.
// Backpressure: none; the caller only asserts we for accepted writes.
module jtag_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  // No reset on the array: contents survive both reset and flush.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jtag_fifo.sv
// Purpose: single-clock TCK FIFO, all DEPTH slots usable; JTAG_FIFO_ERR_EN adds sticky overflow/underflow.
// Latency: FWFT=1 head word visible combinationally; FWFT=0 rd_data/rd_valid one cycle after the read edge.
// Backpressure: writes while full and reads while empty are dropped; flush beats same-cycle requests.
module jtag_fifo
  import jtag_types_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - FIFO_AF_MARGIN_DEF,
  parameter int AE_LEVEL = FIFO_AE_LEVEL_DEF,
  parameter int FWFT     = FIFO_FWFT_DEF
) (
  input  logic                   TCK,
  input  logic                   TRST,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count
`ifdef JTAG_FIFO_ERR_EN
  ,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_bits(DEPTH);

  localparam fifo_cfg_t CFG = '{
    width:    WIDTH,
    depth:    DEPTH,
    af_level: AF_LEVEL,
    ae_level: AE_LEVEL
  };

  localparam logic [CW-1:0] AF_THR = CW'(CFG.af_level);
  localparam logic [CW-1:0] AE_THR = CW'(CFG.ae_level);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  // Pointers run modulo 2*DEPTH; the extra MSB separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  jtag_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (TCK),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = ram_rdata;
    assign rd_valid = !empty;
  end else begin : g_reg_read
    always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else if (flush) begin
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) begin
          rd_data <= ram_rdata;
        end
      end
    end
  end

`ifdef JTAG_FIFO_ERR_EN
  // A request swallowed by flush is not an error.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !flush) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty && !flush) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/jtag_fifo.md
JTAG_FIFO -- requirements
Module: jtag_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, minimum 1.
REQ-002 SHALL have parameter DEPTH, default 64: number of entries, a power of two, minimum 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4: almost_full threshold.
REQ-004 SHALL have parameter AE_LEVEL, default 4: almost_empty threshold.
REQ-005 SHALL have parameter FWFT, default 1: 1 = first-word fall-through, 0 = registered read.
REQ-006 SHALL have port TCK, input, 1 bit: the only clock, rising edge active.
REQ-007 SHALL have port TRST, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have ports wr_en input 1 (write request) and wr_data input WIDTH (write word).
REQ-009 SHALL have ports rd_en input 1 (read request), rd_data output WIDTH (read word) and rd_valid output 1 (rd_data is valid).
REQ-010 SHALL have ports flush input 1 (synchronous empty), full output 1, empty output 1, almost_full output 1, almost_empty output 1.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-012 SHALL have ports overflow output 1, underflow output 1 and err_clr input 1, present only under JTAG_FIFO_ERR_EN.

Function
REQ-013 SHALL make all DEPTH slots usable, with no reserved empty slot.
REQ-014 SHALL use $clog2(DEPTH)+1-bit wr/rd pointers that wrap modulo 2*DEPTH.
- empty when the pointers are equal.
- full when the MSBs differ and the lower bits are equal.
REQ-015 SHALL accept a write iff wr_en and !full; the accepted word is stored at wr_ptr and wr_ptr increments.
REQ-016 SHALL accept a read iff rd_en and !empty; rd_ptr increments.
REQ-017 SHALL decide acceptance from pre-edge flags on simultaneous wr_en and rd_en.
- Full FIFO: the read is accepted and the write is dropped.
- Empty FIFO: the write is accepted and the read is dropped.
- Otherwise both are accepted and count is unchanged.
REQ-018 SHALL register count and update it in the same edge as the pointers: +1 for write only, -1 for read only, 0 otherwise.
REQ-019 SHALL drive almost_full = (count >= AF_LEVEL) and almost_empty = (count <= AE_LEVEL), both combinational from count.
REQ-020 SHALL, when FWFT=1, drive rd_data = mem[rd_ptr] combinationally and rd_valid = !empty; a read acknowledges the displayed word.
REQ-021 SHALL, when FWFT=0, latch rd_data from mem[rd_ptr] on an accepted read and assert rd_valid for exactly the following cycle; rd_data otherwise holds its last value.
REQ-022 SHALL, on a flush edge, zero both pointers and count and deassert rd_valid.
- flush has priority over same-cycle wr_en and rd_en, which are ignored.
- Memory contents are untouched.

Reset
REQ-023 SHALL, while TRST=1, asynchronously zero both pointers, count, rd_data, rd_valid, overflow and underflow.
REQ-024 SHALL therefore read empty=1, full=0, almost_empty=1 and almost_full=0 during reset.
REQ-025 SHALL not reset memory.
REQ-026 SHALL discard any in-flight operation when reset is asserted mid-operation.

Configuration
REQ-027 SHALL, with macro JTAG_FIFO_ERR_EN defined, provide overflow and underflow as sticky flags.
- overflow sets on wr_en while full; underflow sets on rd_en while empty.
- Both clear on err_clr, which has priority over a same-cycle set.
REQ-028 SHALL, without JTAG_FIFO_ERR_EN, omit overflow, underflow and err_clr and their logic; dropped requests are silently ignored.

Structure
REQ-029 SHALL place a shared fifo_cfg_t typedef (width, depth, thresholds) and the default constants in jtag_types_pkg.
REQ-030 SHALL instantiate one storage sub-module, jtag_fifo_ram, with one write port and one asynchronous read port; the pointer and flag logic stays in jtag_fifo.

Verification
REQ-031 SHALL cover fill and wrap: with DEPTH=8, write 0x01..0x08 -> full=1 and count=8 after the 8th edge; read 8 -> 0x01..0x08 in order; repeat twice -> correct across pointer wrap.
REQ-032 SHALL cover simultaneous access.
- Full FIFO, wr_en=rd_en=1 -> count 8->7 and the write is dropped.
- Empty FIFO, same stimulus -> count 0->1 and the read is dropped.
REQ-033 SHALL cover thresholds: DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
- count=5 -> almost_full=0; count=6 -> almost_full=1.
- count=2 -> almost_empty=1; count=3 -> almost_empty=0.
REQ-034 SHALL cover FWFT=0: write 0xA5, then read -> rd_valid=1 and rd_data=0xA5 one cycle after the read edge, rd_valid=0 the next cycle.
REQ-035 SHALL cover flush and reset: count=5 plus flush with wr_en=1 -> count=0 and empty=1; pulse TRST mid-stream -> all outputs reset immediately, without waiting for TCK.
REQ-036 SHALL cover error flags with JTAG_FIFO_ERR_EN: wr_en on full -> overflow=1 and it holds; err_clr -> overflow=0; rd_en on empty -> underflow=1.
